// File: rtl/grf_multiport.sv
// rtl/grf_multiport.sv - multi-port general register file with bypass and background clear sweep (optional GRF_TRACE_EN write trace)
module grf_multiport #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic [31:0]                wpc0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [31:0]                wpc1,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       clr_done
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_PTR  = {ADDR_W{1'b1}};

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                clr_done_q, clr_done_d;

    // Register 0 has no storage; reads of it are forced to zero.
    logic [DATA_W-1:0]   regs_q [1:DEPTH-1];
    logic [DATA_W-1:0]   regs_d [1:DEPTH-1];

    assign clr_busy = (state_q == S_CLEAR);
    assign clr_done = clr_done_q;

    // Clear-sweep sequencing: walk clr_ptr from 1 to the top register, then pulse done.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        clr_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A request arriving during the done pulse is dropped, not queued.
                if (clr_req && !clr_done_q) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = FIRST_PTR;
                end
            end
            S_CLEAR: begin
                if (clr_ptr_q == LAST_PTR) begin
                    state_d    = S_IDLE;
                    clr_ptr_d  = FIRST_PTR;
                    clr_done_d = 1'b1;
                end else begin
                    clr_ptr_d = clr_ptr_q + FIRST_PTR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clr_ptr_q  <= FIRST_PTR;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Next register contents: sweep clear is lowest priority, then port 0, then port 1.
    always_comb begin
        for (int i = 1; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (clr_busy && (clr_ptr_q == ADDR_W'(i))) begin
                regs_d[i] = '0;
            end
            if (we0 && (wa0 == ADDR_W'(i))) begin
                regs_d[i] = wd0;
            end
            if (we1 && (wa1 == ADDR_W'(i))) begin
                regs_d[i] = wd1;
            end
        end
    end

    // Register storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Combinational read ports with same-cycle bypass; a pending sweep clear reads as zero.
    always_comb begin
        rd = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (ra[k*ADDR_W +: ADDR_W] == '0) begin
                rd[k*DATA_W +: DATA_W] = '0;
            end else if (we1 && (wa1 == ra[k*ADDR_W +: ADDR_W])) begin
                rd[k*DATA_W +: DATA_W] = wd1;
            end else if (we0 && (wa0 == ra[k*ADDR_W +: ADDR_W])) begin
                rd[k*DATA_W +: DATA_W] = wd0;
            end else if (clr_busy && (clr_ptr_q == ra[k*ADDR_W +: ADDR_W])) begin
                rd[k*DATA_W +: DATA_W] = '0;
            end else begin
                rd[k*DATA_W +: DATA_W] = regs_q[ra[k*ADDR_W +: ADDR_W]];
            end
        end
    end

`ifdef GRF_TRACE_EN
    // Trace every write that actually lands: port 0 first, skipped when port 1 overrides it.
    always @(posedge clk) begin
        if (reset) begin
            if (we0 && (wa0 != '0) && !(we1 && (wa1 == wa0))) begin
                $display("%d@%h: $%d <= %h", $time, wpc0, wa0, wd0);
            end
            if (we1 && (wa1 != '0)) begin
                $display("%d@%h: $%d <= %h", $time, wpc1, wa1, wd1);
            end
        end
    end
`else
    // The PC inputs only feed the trace; fold them into a sink in the plain build.
    logic unused_wpc;
    assign unused_wpc = ^{wpc0, wpc1};
`endif

endmodule
